// File: rtl/dp_link_pkg.sv
`default_nettype none
// ============================================================================
// Package     : dp_link_pkg
// Description : Shared link-symbol constants and idle-scheduler state
//               encoding for the DP single-lane symbol path.
// Revision    : 1.0 - initial release
// ============================================================================
package dp_link_pkg;

  // Link control / data symbols shared with the SR insertion stage
  localparam logic [7:0] BS    = 8'hBC;
  localparam logic [7:0] BF    = 8'hBD;
  localparam logic [7:0] SR    = 8'h0F;
  localparam logic [7:0] DUMMY = 8'h00;

  // Idle scheduler states
  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_BS1   = 3'd1,
    ST_BF1   = 3'd2,
    ST_BF2   = 3'd3,
    ST_BS2   = 3'd4,
    ST_DUMMY = 3'd5,
    ST_VIDEO = 3'd6
  } sched_state_t;

  // True for the states that make up the idle pattern (BS1..DUMMY)
  function automatic logic is_idle_state(input sched_state_t s);
    logic idle;
    idle = 1'b0;
    case (s)
      ST_BS1, ST_BF1, ST_BF2, ST_BS2, ST_DUMMY: idle = 1'b1;
      default:                                  idle = 1'b0;
    endcase
    return idle;
  endfunction

  // Symbol emitted for a non-video state
  function automatic logic [7:0] idle_symbol(input sched_state_t s);
    logic [7:0] sym;
    sym = DUMMY;
    case (s)
      ST_BS1, ST_BS2: sym = BS;
      ST_BF1, ST_BF2: sym = BF;
      default:        sym = DUMMY;
    endcase
    return sym;
  endfunction

  // Control-symbol flag for a non-video state: set only on BS/BF symbols
  function automatic logic idle_flag(input sched_state_t s);
    logic flag;
    flag = 1'b0;
    case (s)
      ST_BS1, ST_BF1, ST_BF2, ST_BS2: flag = 1'b1;
      default:                        flag = 1'b0;
    endcase
    return flag;
  endfunction

endpackage
`default_nettype wire

// File: rtl/idle_stream_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : idle_stream_scheduler
// Description : Single-lane link-symbol source. Emits the BS-BF-BF-BS idle
//               pattern every IDLE_PERIOD symbols with dummy data between,
//               and lends the link to the video source via req/grant.
// Revision    : 1.0 - initial release
// ============================================================================
module idle_stream_scheduler
  import dp_link_pkg::*;
#(
  parameter int IDLE_PERIOD = 8192,
  parameter int CNT_W       = $clog2(IDLE_PERIOD)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_enable,
  input  logic       vid_req,
  input  logic       vid_control_sym_flag,
  input  logic [7:0] vid_symbols,
  output logic       vid_grant,
  output logic       idle_active,
  output logic       mux_control_sym_flag,
  output logic [7:0] mux_idle_stream_symbols
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IDLE_PERIOD - 1);

  sched_state_t     state;
  sched_state_t     next_state;
  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] next_cnt;
  logic             period_done;

  // The counter holds the symbol index within the current idle period:
  // 0 while BS1 is current, then 1, 2, 3 ... through BF1, BF2, BS2 and DUMMY.
  // The last DUMMY of a period therefore sees IDLE_PERIOD-1, which makes
  // consecutive BS1 starts exactly IDLE_PERIOD cycles apart.
  assign period_done = (period_cnt == LAST_CNT);

  // Next-state selection; a started BS sequence always runs to BS2
  always_comb begin
    next_state = state;
    case (state)
      ST_OFF:   if (cfg_enable) next_state = ST_BS1;
      ST_BS1:   next_state = ST_BF1;
      ST_BF1:   next_state = ST_BF2;
      ST_BF2:   next_state = ST_BS2;
      ST_BS2:   next_state = cfg_enable ? ST_DUMMY : ST_OFF;
      ST_DUMMY: begin
        // Period expiry outranks a pending video request
        if (!cfg_enable)     next_state = ST_OFF;
        else if (period_done) next_state = ST_BS1;
        else if (vid_req)     next_state = ST_VIDEO;
        else                  next_state = ST_DUMMY;
      end
      ST_VIDEO: if (!vid_req || !cfg_enable) next_state = ST_BS1;
      default:  next_state = ST_OFF;
    endcase
  end

  // Period counter update: cleared on entry to BS1, advanced on entry to
  // BF1..DUMMY, held otherwise so it can never wrap
  always_comb begin
    next_cnt = period_cnt;
    case (next_state)
      ST_BS1:                             next_cnt = '0;
      ST_BF1, ST_BF2, ST_BS2, ST_DUMMY:   next_cnt = period_cnt + CNT_W'(1);
      default:                            next_cnt = period_cnt;
    endcase
  end

  // State, counter and the output register stage driven from the current state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                   <= ST_OFF;
      period_cnt              <= '0;
      vid_grant               <= 1'b0;
      idle_active             <= 1'b0;
      mux_control_sym_flag    <= 1'b0;
      mux_idle_stream_symbols <= 8'h00;
    end else begin
      state       <= next_state;
      period_cnt  <= next_cnt;
      vid_grant   <= (state == ST_VIDEO);
      idle_active <= is_idle_state(state);
      if (state == ST_VIDEO) begin
        mux_idle_stream_symbols <= vid_symbols;
        mux_control_sym_flag    <= vid_control_sym_flag;
      end else begin
        mux_idle_stream_symbols <= idle_symbol(state);
        mux_control_sym_flag    <= idle_flag(state);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_idle_stream_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_idle_stream_scheduler
// Description : Directed self-checking bench for idle_stream_scheduler with
//               IDLE_PERIOD=16.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_idle_stream_scheduler;

  logic       clk;
  logic       rst_n;
  logic       cfg_enable;
  logic       vid_req;
  logic       vid_flag;
  logic [7:0] vid_sym;
  logic       vid_grant;
  logic       idle_active;
  logic       mux_flag;
  logic [7:0] mux_sym;

  int n_checks = 0;
  int n_fails  = 0;

  idle_stream_scheduler #(
    .IDLE_PERIOD (16)
  ) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .cfg_enable              (cfg_enable),
    .vid_req                 (vid_req),
    .vid_control_sym_flag    (vid_flag),
    .vid_symbols             (vid_sym),
    .vid_grant               (vid_grant),
    .idle_active             (idle_active),
    .mux_control_sym_flag    (mux_flag),
    .mux_idle_stream_symbols (mux_sym)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [7:0] sym, input logic flag,
                            input logic grant, input logic idle);
    check_eq({tag, ".sym"},   32'(mux_sym),     32'(sym));
    check_eq({tag, ".flag"},  32'(mux_flag),    32'(flag));
    check_eq({tag, ".grant"}, 32'(vid_grant),   32'(grant));
    check_eq({tag, ".idle"},  32'(idle_active), 32'(idle));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Four cycles of BS,BF,BF,BS as seen on the output
  task automatic bs_seq(input string tag);
    tick; expect_out({tag, ".bs1"}, 8'hBC, 1'b1, 1'b0, 1'b1);
    tick; expect_out({tag, ".bf1"}, 8'hBD, 1'b1, 1'b0, 1'b1);
    tick; expect_out({tag, ".bf2"}, 8'hBD, 1'b1, 1'b0, 1'b1);
    tick; expect_out({tag, ".bs2"}, 8'hBC, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic dummies(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick; expect_out(tag, 8'h00, 1'b0, 1'b0, 1'b1);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    cfg_enable = 1'b0;
    vid_req    = 1'b0;
    vid_flag   = 1'b0;
    vid_sym    = 8'h00;
    repeat (3) tick;
    expect_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);

    // Plain idle: OFF cycle, then the pattern repeating every 16 symbols
    rst_n      = 1'b1;
    cfg_enable = 1'b1;
    tick; expect_out("off_exit", 8'h00, 1'b0, 1'b0, 1'b0);
    bs_seq("idle0");
    dummies("idle0_dummy", 12);
    bs_seq("idle1");

    // Video request raised in the first DUMMY after BS2
    vid_req  = 1'b1;
    vid_sym  = 8'h10;
    vid_flag = 1'b0;
    tick; expect_out("vid_wait", 8'h00, 1'b0, 1'b0, 1'b1);
    vid_sym  = 8'h11;
    vid_flag = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick;
      expect_out("vid_echo", 8'h11 + 8'(i), (8'h11 + 8'(i)) == 8'h13, 1'b1, 1'b0);
      vid_sym  = 8'h12 + 8'(i);
      vid_flag = ((8'h12 + 8'(i)) == 8'h13);
    end

    // Request dropped: one more echoed symbol, then a fresh BS sequence
    vid_req = 1'b0;
    tick; expect_out("vid_last", 8'h17, 1'b0, 1'b1, 1'b0);
    bs_seq("resume");
    dummies("resume_dummy", 12);

    // Request arriving on the last DUMMY of the period: BS sequence wins
    bs_seq("prio_pre");
    dummies("prio_dummy", 11);
    vid_req  = 1'b1;
    vid_sym  = 8'h5A;
    vid_flag = 1'b1;
    tick; expect_out("prio_last_dummy", 8'h00, 1'b0, 1'b0, 1'b1);
    bs_seq("prio_bs");
    tick; expect_out("prio_dummy_first", 8'h00, 1'b0, 1'b0, 1'b1);
    tick; expect_out("prio_video", 8'h5A, 1'b1, 1'b1, 1'b0);
    vid_req = 1'b0;
    tick; expect_out("prio_video_end", 8'h5A, 1'b1, 1'b1, 1'b0);
    tick; expect_out("prio_back_bs1", 8'hBC, 1'b1, 1'b0, 1'b1);

    // BF1 is now current: disabling still completes the sequence
    cfg_enable = 1'b0;
    tick; expect_out("dis_bf1", 8'hBD, 1'b1, 1'b0, 1'b1);
    tick; expect_out("dis_bf2", 8'hBD, 1'b1, 1'b0, 1'b1);
    tick; expect_out("dis_bs2", 8'hBC, 1'b1, 1'b0, 1'b1);
    tick; expect_out("dis_off", 8'h00, 1'b0, 1'b0, 1'b0);
    cfg_enable = 1'b1;
    tick; expect_out("reen_off", 8'h00, 1'b0, 1'b0, 1'b0);
    tick; expect_out("reen_bs1", 8'hBC, 1'b1, 1'b0, 1'b1);
    tick; expect_out("reen_bf1", 8'hBD, 1'b1, 1'b0, 1'b1);

    // BF2 is now current: asynchronous reset clears outputs at once
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("async_rst", 8'h00, 1'b0, 1'b0, 1'b0);
    tick; expect_out("rst_hold", 8'h00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick; expect_out("rst_off", 8'h00, 1'b0, 1'b0, 1'b0);
    bs_seq("rst_restart");
    tick; expect_out("rst_dummy", 8'h00, 1'b0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Safety net so the run always ends
  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
